// File: rtl/rect_calc_pkg.sv
// Shared types and constants for the rect_calc perimeter/area unit.
package rect_calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic MODE_PERIM = 1'b0;
  localparam logic MODE_AREA  = 1'b1;

  // Step counter width for an n-step multiply; never narrower than one bit.
  function automatic int unsigned step_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, LSB first.
module shift_add_mul
  import rect_calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = step_cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // product is taken combinationally so the final partial sum lands on the done edge
  assign done    = busy && (cnt == LAST);
  assign product = acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= (2*N)'(a);
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rect_calc.sv
// Handshake-driven rectangle unit: perimeter 2(a+b) in one cycle or area a*b in N cycles.
module rect_calc
  import rect_calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           mode,
  input  logic           dav_,
  output logic           rfd,
  output logic [2*N-1:0] out
);

  state_t state;
  state_t state_next;

  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           mode_q;
  logic           accept;
  logic           out_we;
  logic [2*N-1:0] out_d;
  logic [2*N-1:0] perim;
  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_product;

  assign accept = (state == IDLE) && !dav_;
  assign rfd    = (state == IDLE);
  assign perim  = ((2*N)'(a_q) + (2*N)'(b_q)) << 1;

  // The multiplier loads straight from the ports on the accepting edge so its
  // N steps finish on edge k+N rather than k+N+1.
  shift_add_mul #(
    .N(N)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (accept && (mode == MODE_AREA)),
    .a      (a),
    .b      (b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_we     = 1'b0;
    out_d      = '0;
    case (state)
      IDLE: begin
        if (!dav_) state_next = CALC;
      end
      CALC: begin
        if (mode_q == MODE_PERIM) begin
          out_we     = 1'b1;
          out_d      = perim;
          state_next = DONE;
        end else if (mul_done) begin
          out_we     = 1'b1;
          out_d      = mul_product;
          state_next = DONE;
        end else if (!mul_busy) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        if (dav_) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_PERIM;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       out <= '0;
    else if (out_we) out <= out_d;
  end

endmodule

// File: tb/tb_rect_calc.sv
// Scoreboard bench for rect_calc (N=4): expected results queued on drive, checked on completion.
module tb_rect_calc;

  localparam int unsigned N  = 4;
  localparam int unsigned OW = 2 * N;

  typedef struct {
    logic [OW-1:0] exp;
    int            lat;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  a     = '0;
  logic [N-1:0]  b     = '0;
  logic          mode  = 1'b0;
  logic          dav_  = 1'b1;
  logic          rfd;
  logic [OW-1:0] out;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rect_calc #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .mode (mode),
    .dav_ (dav_),
    .rfd  (rfd),
    .out  (out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: samples handshake just before each edge, checks outputs at the following negedge.
  initial begin : monitor
    logic          rst_s;
    logic          acc_s;
    logic [OW-1:0] prev_out;
    int            cd;
    bit            busy_tx;
    exp_t          e;
    prev_out = '0;
    cd       = 0;
    busy_tx  = 1'b0;
    forever begin
      @(posedge clock);
      rst_s = reset;
      acc_s = rfd && !dav_ && !reset;
      @(negedge clock);
      if (rst_s) begin
        if (busy_tx) begin
          void'(sb.pop_front());
          busy_tx = 1'b0;
        end
      end else begin
        if (busy_tx) begin
          cd--;
          if (cd == 0) begin
            e = sb.pop_front();
            check("result", out, e.exp);
            busy_tx = 1'b0;
          end else begin
            check("hold_until_final", out, prev_out);
          end
        end else begin
          check("out_stable", out, prev_out);
        end
        if (acc_s) begin
          check("sb_has_entry", sb.size(), 1);
          if (sb.size() > 0) begin
            busy_tx = 1'b1;
            cd      = sb[0].lat;
          end
          check("rfd_fall", rfd, 0);
        end
      end
      prev_out = out;
    end
  end

  task automatic wait_rfd();
    int t = 0;
    while (rfd !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("rfd_ready", rfd, 1);
  endtask

  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tm,
                      output int acc_at);
    exp_t e;
    int   ea;
    int   eb;
    ea    = int'(ta);
    eb    = int'(tb);
    e.lat = tm ? int'(N) : 1;
    e.exp = tm ? OW'(ea * eb) : OW'(2 * (ea + eb));
    a     = ta;
    b     = tb;
    mode  = tm;
    dav_  = 1'b0;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    acc_at = cyc;
    a      = N'($urandom);
    b      = N'($urandom);
    mode   = 1'($urandom);
  endtask

  task automatic txn(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tm,
                     input int hold, output int acc_at);
    int lat;
    lat = tm ? int'(N) : 1;
    wait_rfd();
    send(ta, tb, tm, acc_at);
    repeat (lat + hold) begin
      @(negedge clock);
      check("rfd_low", rfd, 0);
    end
    dav_ = 1'b1;
    @(negedge clock);
    check("rfd_rise", rfd, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int acc_at;
    int prev_acc;
    int prev_lat;
    logic [4:0] iv;
    logic tm;

    reset = 1'b1;
    dav_  = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_rfd", rfd, 1);
    check("reset_out", out, 0);
    repeat (3) begin
      @(negedge clock);
      check("idle_rfd", rfd, 1);
    end

    for (int i = 0; i < 32; i++) begin
      iv = 5'(i);
      txn(N'(iv[4:1] + 4'd3), N'(iv[3:0] + 4'd1), 1'b0, 0, acc_at);
    end
    txn(4'd15, 4'd15, 1'b0, 0, acc_at);
    txn(4'd15, 4'd15, 1'b1, 0, acc_at);
    txn(4'd7,  4'd0,  1'b1, 0, acc_at);

    // dav_ low for 10 cycles after acceptance
    txn(4'd3, 4'd5, 1'b1, 10 - int'(N), acc_at);

    // reset sampled on the second edge of an area computation
    wait_rfd();
    send(4'd9, 4'd13, 1'b1, acc_at);
    @(negedge clock);
    reset = 1'b1;
    dav_  = 1'b1;
    @(negedge clock);
    check("midop_rst_rfd", rfd, 1);
    check("midop_rst_out", out, 0);
    reset = 1'b0;
    txn(4'd5, 4'd6, 1'b0, 0, acc_at);

    prev_acc = acc_at;
    prev_lat = 1;
    for (int i = 0; i < 10; i++) begin
      tm = (i % 2 == 0);
      txn(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), tm, 0, acc_at);
      check("spacing", acc_at - prev_acc, prev_lat + 2);
      prev_acc = acc_at;
      prev_lat = tm ? int'(N) : 1;
    end

    repeat (3) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_calc.md
# rect_calc

Parametrised successor of the rectangle-perimeter unit: a handshake-driven arithmetic block that takes two N-bit side lengths and returns either the perimeter 2·(a+b) or the area a·b, selected per transaction by a mode bit. It keeps the same producer-facing dav_/rfd protocol, so existing producer/consumer benches drive it unchanged. The area path uses a multi-cycle shift-add multiplier, so latency depends on the selected mode.

## Interface
- N, default 4: width of each side operand; legal range N ≥ 2.
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- a  in  N  side A; sampled only on the accepting edge.
- b  in  N  side B; sampled only on the accepting edge.
- mode  in  1  0 = perimeter, 1 = area; sampled with a and b.
- dav_  in  1  active-low data-available from the producer.
- rfd  out  1  ready-for-data; 1 = idle and able to accept.
- out  out  2N  result register, zero-extended. Perimeter needs at most N+2 bits, which is ≤ 2N for N ≥ 2.

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE: rfd=1.
  - On an edge with dav_==0, latch a, b and mode, go to CALC, and set rfd=0.
- CALC, perimeter:
  - One cycle.
  - out ← ({a}+{b})<<1, computed at 2N width.
  - Go to DONE.
- CALC, area:
  - N-cycle shift-add over the latched b, LSB first.
  - Accumulator is 2N bits; a is shifted left each step.
  - On the final step, out ← product and go to DONE.
- DONE: rfd=0.
  - Wait for dav_==1; on that edge go to IDLE and set rfd=1.
  - If dav_ is still 0, remain in DONE, so one producer request never triggers twice.
- dav_ is ignored while in CALC.
- a, b and mode may go X after rfd falls.
- out holds its value from one result write to the next.
- out is never written outside the final CALC edge, so a consumer watching for out changes sees at most one update per transaction.
- Reset, from any state including mid-CALC:
  - State goes to IDLE, rfd=1, out=0.
  - The accumulator, latched operands and step counter are cleared.
  - An in-flight transaction is abandoned and produces no write.
- Reset has priority over dav_ in the same cycle.

## Timing
- Edge numbering: let edge k be the first posedge in IDLE with dav_ low.
- rfd falls after edge k.
- Perimeter: out is valid after edge k+1, and the state is DONE after edge k+1.
- Area: out is valid after edge k+N, and the state is DONE after edge k+N.
- rfd rises after the first edge in DONE that samples dav_==1, which is at least one cycle after the out update.
  - Earliest rise: edge k+2 for perimeter, k+N+1 for area.
- Next acceptance is possible at the edge after rfd rises.
- Minimum transaction spacing: 3 cycles for perimeter, N+2 for area.
- Outputs after reset deassertion: rfd=1, out=0.

## Structure
- Package rect_calc_pkg holds:
  - the state typedef (IDLE/CALC/DONE);
  - constants MODE_PERIM=1'b0 and MODE_AREA=1'b1;
  - a width helper for the step counter, $clog2(N).
- Sub-module shift_add_mul (parameter N) holds the multiplier datapath.
  - Ports: clock, reset, start, a, b, busy, done, product[2N-1:0].
  - done is a one-cycle pulse on the final step.
- The top level holds the FSM, the operand registers, the perimeter adder and the out register.

## Test plan
All scenarios use N=4.
- Reset check: reset=1 for 2 cycles, then 0 → rfd=1, out=0; rfd stays 1 with dav_ high.
- Perimeter sweep:
  - Run the 32-case sweep with a=i[4:1]+3, b=i[3:0]+1, mode=0, full handshake each time.
  - Required result per case: out=2·(a+b) mod 64 on N+2 bits, zero-extended, e.g. a=3, b=1 → 8.
  - Also a=15, b=15 → 60.
  - Expect exactly 1 out update per transaction.
- Area:
  - a=15, b=15, mode=1 → out=225 exactly 4 cycles after acceptance.
  - a=7, b=0 → out=0; the previous out value must be overwritten only at the final edge.
- Held dav_: keep dav_ low for 10 cycles after acceptance → a single result; rfd stays 0 until dav_ rises, then rises 1 edge later; no second computation.
- Mid-operation reset: assert reset at cycle 2 of an area computation (a=9, b=13) → out=0, rfd=1 next edge; a following perimeter request a=5, b=6 → out=22.
- Back-to-back: alternate area and perimeter requests with dav_ re-asserted immediately on rfd rise → all results correct; minimum spacing holds (3 / N+2 cycles).
